// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: state encoding and default sizes.
package div_issue_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StBusy  = BUSY,
        StDone  = DONE
    } state_e;

    localparam int unsigned TAG_W_DEF       = 6;
    localparam int unsigned TIMEOUT_DEF     = 48;
    localparam int unsigned DIV_NOMINAL_LAT = 33;
    localparam int unsigned CNT_W           = 6;

endpackage

// File: rtl/div_issue_ctrl.sv
// Front-end for the multicycle radix-2 divider: accepts one tagged op, sequences the divider,
// short-circuits divide-by-zero, guards against a hung divider and presents the result to the CDB.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_dividend_i,
    input  logic [31:0]      req_divisor_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      div_dividend_o,
    output logic [31:0]      div_divisor_o,
    output logic             div_start_o,
    input  logic             div_ready_i,
    input  logic [31:0]      div_result_i,
    input  logic             div_exception_i,
    output logic             cdb_valid_o,
    input  logic             cdb_grant_i,
    output logic [TAG_W-1:0] cdb_tag_o,
    output logic [31:0]      cdb_data_o,
    output logic             cdb_exc_o,
    output logic             busy_o,
    output logic             timeout_err_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [31:0]        dividend_q;
    logic [31:0]        divisor_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        data_q;
    logic               exc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               timeout_q;

    logic divisor_zero;
    logic can_accept;
    logic accept;

    assign divisor_zero = ~|req_divisor_i;
    // A slot frees up in IDLE, or in DONE during the grant cycle; flush always blocks intake.
    assign can_accept   = !flush_i &&
                          ((state_q == StIdle) || ((state_q == StDone) && cdb_grant_i));
    assign accept       = req_valid_i && can_accept;

    assign req_ready_o    = can_accept && rst_ni;
    assign div_start_o    = (state_q == StStart);
    assign cdb_valid_o    = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign cdb_tag_o      = tag_q;
    assign cdb_data_o     = data_q;
    assign cdb_exc_o      = exc_q;
    assign timeout_err_o  = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            dividend_q <= '0;
            divisor_q  <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            exc_q      <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_q <= StIdle;
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StBusy;
                end
                StBusy: begin
                    if (div_ready_i) begin
                        data_q  <= div_result_i;
                        exc_q   <= div_exception_i;
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        data_q    <= '0;
                        exc_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    if (cdb_grant_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Accepting overrides the case above, including the back-to-back grant cycle.
            if (accept) begin
                dividend_q <= req_dividend_i;
                divisor_q  <= req_divisor_i;
                tag_q      <= req_tag_i;
                if (divisor_zero) begin
                    data_q  <= '0;
                    exc_q   <= 1'b1;
                    state_q <= StDone;
                end else begin
                    state_q <= StStart;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: vector table, randomized ops against a reference
// model, and hand-written flush / back-to-back / timeout / async-reset sequences.
module tb_div_issue_ctrl;

    localparam int TAG_W   = 6;
    localparam int TIMEOUT = 48;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_dividend;
    logic [31:0]      req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic             div_start;
    logic             div_ready;
    logic [31:0]      div_result;
    logic             div_exception;
    logic             cdb_valid;
    logic             cdb_grant;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             cdb_exc;
    logic             busy;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;
    int lat_cfg = 33;
    int rem = 0;

    div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_dividend_i (req_dividend),
        .req_divisor_i  (req_divisor),
        .req_tag_i      (req_tag),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_start_o    (div_start),
        .div_ready_i    (div_ready),
        .div_result_i   (div_result),
        .div_exception_i(div_exception),
        .cdb_valid_o    (cdb_valid),
        .cdb_grant_i    (cdb_grant),
        .cdb_tag_o      (cdb_tag),
        .cdb_data_o     (cdb_data),
        .cdb_exc_o      (cdb_exc),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; afterwards model the divider: ready lat_cfg cycles after start.
    task automatic tick();
        @(posedge clk);
        #1;
        div_ready     = 1'b0;
        div_exception = 1'b0;
        if (flush) rem = 0;
        if (div_start) begin
            rem = lat_cfg;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                div_ready  = 1'b1;
                div_result = (div_divisor == 0) ? 32'hDEAD_BEEF :
                             32'($signed(div_dividend) / $signed(div_divisor));
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!cdb_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input int lat,
                                  output logic [31:0] d, output logic e, output int cyc);
        if (b == 0) begin
            d = 0; e = 1'b1; cyc = 1;
        end else if (lat < 1 || lat > TIMEOUT) begin
            d = 0; e = 1'b1; cyc = 2 + TIMEOUT;
        end else begin
            d = 32'($signed(a) / $signed(b)); e = 1'b0; cyc = 2 + lat;
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tg,
                         input int lat, input int gd, input logic [31:0] ed, input logic ee,
                         input int el);
        int t;
        int starts;
        logic opbad;
        logic holdbad;
        lat_cfg = lat;
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_tag = tg;
        #1;
        chk("accept_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0; req_dividend = $urandom; req_divisor = $urandom; req_tag = '0;
        t = 1; starts = 0; opbad = 1'b0;
        while (!cdb_valid && t <= TIMEOUT + 10) begin
            if (div_start) starts++;
            if (div_dividend !== a || div_divisor !== b) opbad = 1'b1;
            tick();
            t++;
        end
        if (div_dividend !== a || div_divisor !== b) opbad = 1'b1;
        chk("latency", 64'(t), 64'(el));
        chk("start_pulses", 64'(starts), (b == 0) ? 64'(0) : 64'(1));
        chk("operands_stable", 64'(opbad), 64'(0));
        chk("cdb_tag", 64'(cdb_tag), 64'(tg));
        chk("cdb_data", 64'(cdb_data), 64'(ed));
        chk("cdb_exc", 64'(cdb_exc), 64'(ee));
        holdbad = 1'b0;
        for (int i = 0; i < gd; i++) begin
            tick();
            if (!cdb_valid || cdb_tag !== tg || cdb_data !== ed || cdb_exc !== ee ||
                req_ready) holdbad = 1'b1;
        end
        chk("hold_stable", 64'(holdbad), 64'(0));
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        chk("idle_after_grant", 64'({busy, cdb_valid}), 64'(0));
    endtask

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               gd;
        logic [31:0]      ed;
        logic             ee;
        int               el;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n;
        logic flag;
        logic [31:0] ra, rb, ed;
        logic ee;
        int el, rl;

        vt[0] = '{32'd100, 32'(-7), 6'd5, 33, 0, 32'(-14), 1'b0, 35};
        vt[1] = '{32'd42, 32'd0, 6'd3, 33, 0, 32'd0, 1'b1, 1};
        vt[2] = '{32'(-100), 32'd7, 6'd9, 5, 2, 32'(-14), 1'b0, 7};
        vt[3] = '{32'd7, 32'd100, 6'd11, 1, 0, 32'd0, 1'b0, 3};
        vt[4] = '{32'(-9), 32'(-2), 6'd63, 40, 1, 32'd4, 1'b0, 42};
        vt[5] = '{32'd0, 32'd0, 6'd0, 1, 3, 32'd0, 1'b1, 1};
        vt[6] = '{32'h8000_0001, 32'd2, 6'd33, 48, 0, 32'hC000_0001, 1'b0, 50};

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_tag = '0; div_ready = 1'b0; div_result = '0; div_exception = 1'b0;
        cdb_grant = 1'b0;
        #1;
        chk("reset_outputs_zero", 64'(|{req_ready, div_dividend, div_divisor, div_start,
            cdb_valid, cdb_tag, cdb_data, cdb_exc, busy, timeout_err}), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'(req_ready), 64'(1));
        chk("idle_after_reset", 64'({busy, cdb_valid, div_start, timeout_err}), 64'(0));

        foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].tag, vt[i].lat, vt[i].gd,
                              vt[i].ed, vt[i].ee, vt[i].el);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'(int'($urandom_range(0, 40)) - 20);
            rl = int'($urandom_range(1, 40));
            model(ra, rb, rl, ed, ee, el);
            do_op(ra, rb, 6'($urandom), rl, int'($urandom_range(0, 3)), ed, ee, el);
        end

        // Grant withheld in DONE, then back-to-back accept in the grant cycle.
        lat_cfg = 3;
        req_valid = 1'b1; req_dividend = 32'd50; req_divisor = 32'd5; req_tag = 6'd7;
        tick();
        req_dividend = 32'(-30); req_divisor = 32'(-3); req_tag = 6'd8;
        wait_valid(n);
        chk("b2b_first_data", 64'(cdb_data), 64'(10));
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready || !cdb_valid || cdb_tag !== 6'd7 || cdb_data !== 32'd10 ||
                cdb_exc) flag = 1'b1;
            tick();
        end
        chk("b2b_hold_no_accept", 64'(flag), 64'(0));
        cdb_grant = 1'b1;
        #1;
        chk("b2b_ready_on_grant", 64'(req_ready), 64'(1));
        tick();
        cdb_grant = 1'b0; req_valid = 1'b0;
        chk("b2b_start_next", 64'({div_start, cdb_valid, busy}), 64'(3'b101));
        wait_valid(n);
        chk("b2b_second_tag", 64'(cdb_tag), 64'(8));
        chk("b2b_second_data", 64'(cdb_data), 64'(10));
        cdb_grant = 1'b1; tick(); cdb_grant = 1'b0;

        // Flush at BUSY cycle 10, with a request offered in the same cycle.
        lat_cfg = 33;
        req_valid = 1'b1; req_dividend = 32'd77; req_divisor = 32'd7; req_tag = 6'd12;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1; req_valid = 1'b1; req_tag = 6'd13;
        #1;
        chk("flush_blocks_ready", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_to_idle", 64'({busy, cdb_valid}), 64'(0));
        flag = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (busy || cdb_valid) flag = 1'b1;
        end
        div_ready = 1'b1; div_result = 32'd123; div_exception = 1'b1;
        tick();
        tick();
        if (busy || cdb_valid) flag = 1'b1;
        chk("stale_ready_ignored", 64'(flag), 64'(0));
        do_op(32'd77, 32'd7, 6'd13, 33, 0, 32'd11, 1'b0, 35);

        // Grant and flush together: the result is dropped and nothing is accepted.
        req_valid = 1'b1; req_dividend = 32'd5; req_divisor = 32'd0; req_tag = 6'd2;
        tick();
        chk("gf_valid", 64'(cdb_valid), 64'(1));
        cdb_grant = 1'b1; flush = 1'b1;
        #1;
        chk("gf_no_ready", 64'(req_ready), 64'(0));
        tick();
        cdb_grant = 1'b0; flush = 1'b0; req_valid = 1'b0;
        chk("gf_idle", 64'({busy, cdb_valid}), 64'(0));

        // Divider never answers: watchdog abort.
        chk("no_timeout_yet", 64'(timeout_err), 64'(0));
        do_op(32'd1000, 32'd3, 6'd20, 0, 0, 32'd0, 1'b1, 2 + TIMEOUT);
        chk("timeout_sticky", 64'(timeout_err), 64'(1));
        tick();
        chk("timeout_still_set", 64'(timeout_err), 64'(1));

        // Asynchronous reset in the middle of BUSY.
        lat_cfg = 33;
        req_valid = 1'b1; req_dividend = 32'd9; req_divisor = 32'd4; req_tag = 6'd44;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(|{req_ready, div_dividend, div_divisor, div_start,
            cdb_valid, cdb_tag, cdb_data, cdb_exc, busy, timeout_err}), 64'(0));
        rem = 0;
        #3 rst_n = 1'b1;
        #1;
        chk("ready_after_release", 64'(req_ready), 64'(1));
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (div_start || busy || cdb_valid || timeout_err) flag = 1'b1;
        end
        chk("no_spurious_start", 64'(flag), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Front-end controller for the multicycle radix-2 divider.
- Accepts one tagged divide op from the integer reservation station and holds its operands stable for the whole divide.
- Pulses the divider start (ctrl_div) and waits for its ready, or short-circuits divide-by-zero without starting the divider.
- Presents the tagged result on the CDB request interface until granted; honours pipeline flush.

Parameters:
- TAG_W, 6, ROB tag width.
- TIMEOUT, 48, cycles in BUSY before watchdog abort (divider nominal latency 33).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill any in-flight op (mispredict/exception recovery).
- req_valid  in  1  RS offers a divide op.
- req_ready  out  1  controller can accept an op this cycle.
- req_dividend  in  32  signed dividend.
- req_divisor  in  32  signed divisor.
- req_tag  in  TAG_W  destination ROB tag.
- div_dividend  out  32  registered dividend to the divider.
- div_divisor  out  32  registered divisor to the divider.
- div_start  out  1  one-cycle start pulse (divider ctrl_div).
- div_ready  in  1  divider done.
- div_result  in  32  signed quotient from the divider.
- div_exception  in  1  divider divide-by-zero flag.
- cdb_valid  out  1  result pending for the CDB.
- cdb_grant  in  1  CDB arbiter accepts the result this cycle.
- cdb_tag  out  TAG_W  tag of the pending result.
- cdb_data  out  32  quotient.
- cdb_exc  out  1  exception (divide-by-zero or timeout).
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog flag, cleared only by reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, except req_ready=1 once reset is released.
  - Operand, tag and result registers cleared to 0.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch dividend, divisor and tag.
  - If req_divisor==0: go to DONE with cdb_data=0, cdb_exc=1; div_start is never asserted.
  - Otherwise go to START.
- START:
  - div_start=1 for exactly this one cycle.
  - Watchdog counter cleared to 0.
  - Next state BUSY.
- BUSY:
  - div_start=0; watchdog counter increments every cycle.
  - div_ready=1: capture div_result into cdb_data and div_exception into cdb_exc, then go to DONE.
  - Counter reaches TIMEOUT-1 with no div_ready: go to DONE with cdb_data=0, cdb_exc=1, and set timeout_err.
- DONE:
  - cdb_valid=1; cdb_tag, cdb_data and cdb_exc held stable until grant.
  - On cdb_grant, go to IDLE.
  - req_ready=cdb_grant, so back-to-back accept is allowed. A request accepted in the grant cycle follows the IDLE accept rules and goes straight to START, or to DONE for divisor==0.
- div_dividend and div_divisor are driven from the latched registers. They are stable from START through the end of DONE, because the divider samples operand signs at completion.
- div_ready is ignored outside BUSY. This covers stale ready pulses after a flush.
- flush (highest priority, any state):
  - Next state IDLE; cdb_valid=0 from the next cycle.
  - A request presented in the same cycle is not accepted (req_ready forced 0).
  - A divider already started is abandoned. The next div_start restarts its counter.
- Simultaneous cdb_grant and flush: flush wins; the result is dropped.
- Tag, data and exc never change while cdb_valid=1.
- Latency, accept to cdb_valid:
  - Normal divide: accept, then START, then BUSY for N cycles, then DONE. cdb_valid rises 2+N cycles after accept, where N is the number of BUSY cycles up to and including the div_ready cycle. Nominally N=33.
  - Divide-by-zero: cdb_valid rises 1 cycle after accept.

Decomposition:
- Shared processor package:
  - state encoding localparams: IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3;
  - TAG_W default;
  - DIV_NOMINAL_LAT=33.
- No sub-module needed.
- The watchdog is an inline 6-bit counter.
- The zero-divisor check is an inline 32-input NOR on req_divisor.

Test Plan:
- 100 / -7, tag 5, divider model ready after 33 cycles -> div_start pulses once; cdb_valid at accept+35; cdb_tag=5, cdb_data=-14, cdb_exc=0; grant returns busy to 0 the next cycle.
- Divisor 0, dividend 42, tag 3 -> no div_start; cdb_valid the next cycle; cdb_data=0, cdb_exc=1, tag 3.
- Hold cdb_grant low for 10 cycles in DONE -> outputs stable; req_ready=0; a new req_valid is not accepted until the grant cycle. A back-to-back op accepted at grant with divisor -3 enters START on the next cycle (div_start=1 then).
- flush asserted at BUSY cycle 10, then a stale div_ready injected 23 cycles later -> state IDLE; no cdb_valid. A new op 1 cycle after flush completes with the correct tag and quotient.
- Divider model never asserts ready -> after TIMEOUT BUSY cycles cdb_valid=1, cdb_exc=1, cdb_data=0; timeout_err=1 and stays set after grant.
- reset_n dropped mid-BUSY, asynchronously -> all outputs 0 immediately. After release req_ready=1 and no spurious div_start.
